// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared FSM state and parity encodings for the FIFO-fed UART transmitter
package fifo_uart_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_START      = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_PARITY_BIT = 3'd3;
  localparam logic [2:0] ST_STOP       = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - per-bit cycle counter; flags the final cycle of each serial bit
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_bit_last
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_bit_last = (r_cnt == LAST_CNT);

  // Wrapping on bit_last lets consecutive bits in the same state share one counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_bit_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the async FIFO read port and sends them as UART frames
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DSIZE        = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             tx_en,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DSIZE - 1);

  logic [2:0]       r_state;
  logic [DSIZE-1:0] r_shreg;
  logic [BW-1:0]    r_bit_idx;
  logic             r_par;
  logic             r_tx;
  logic             r_busy;
  logic             r_tx_done;

  logic [2:0]       w_state_next;
  logic [DSIZE-1:0] w_shreg_next;
  logic             w_tx_next;
  logic             w_bit_last;
  logic             w_last_data;
  logic             w_pop;
  logic             w_clear;

  assign w_pop = rrst_n & tx_en & ~rempty &
                 ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_last));
  assign w_last_data = (r_bit_idx == LAST_BIT);
  assign w_clear     = w_pop | (w_state_next != r_state);

  assign rinc    = w_pop;
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk     (rclk),
    .i_rst_n   (rrst_n),
    .i_clear   (w_clear),
    .o_bit_last(w_bit_last)
  );

  always_comb begin
    w_state_next = r_state;
    w_shreg_next = r_shreg;
    case (r_state)
      ST_IDLE:       if (w_pop) w_state_next = ST_START;
      ST_START:      if (w_bit_last) w_state_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_last) begin
          w_shreg_next = r_shreg >> 1;
          if (w_last_data) begin
            w_state_next = (PARITY != PARITY_NONE) ? ST_PARITY_BIT : ST_STOP;
          end
        end
      end
      ST_PARITY_BIT: if (w_bit_last) w_state_next = ST_STOP;
      ST_STOP:       if (w_bit_last) w_state_next = w_pop ? ST_START : ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
    if (w_pop) begin
      w_shreg_next = rdata;
    end
  end

  // The line level is registered from the next state so tx changes on the same edge as the FSM.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      ST_START:      w_tx_next = 1'b0;
      ST_DATA:       w_tx_next = w_shreg_next[0];
      ST_PARITY_BIT: w_tx_next = r_par;
      default:       w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != ST_IDLE);
      r_tx_done <= (r_state == ST_STOP) & w_bit_last;
      if (w_pop) begin
        r_par     <= (^rdata) ^ (PARITY == PARITY_ODD);
        r_bit_idx <= '0;
      end else if ((r_state == ST_DATA) && w_bit_last) begin
        r_bit_idx <= w_last_data ? '0 : r_bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - bench for fifo_uart_tx: three parity variants against a frame-timeline model
module tb_fifo_uart_tx;

  localparam int CPB  = 4;
  localparam int HIST = 512;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       tx_en;
  logic [7:0] rdata [3];
  logic [2:0] rempty;
  logic [2:0] rinc;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] tx_done;

  always #5 rclk = ~rclk;

  fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(CPB), .PARITY(0)) u_dut0 (
    .rclk(rclk), .rrst_n(rrst_n), .tx_en(tx_en), .rdata(rdata[0]), .rempty(rempty[0]),
    .rinc(rinc[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]));
  fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(CPB), .PARITY(1)) u_dut1 (
    .rclk(rclk), .rrst_n(rrst_n), .tx_en(tx_en), .rdata(rdata[1]), .rempty(rempty[1]),
    .rinc(rinc[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]));
  fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(CPB), .PARITY(2)) u_dut2 (
    .rclk(rclk), .rrst_n(rrst_n), .tx_en(tx_en), .rdata(rdata[2]), .rempty(rempty[2]),
    .rinc(rinc[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [2:0] pop_seen = '0;

  logic h_tx   [3][HIST];
  logic h_busy [3][HIST];
  logic h_done [3][HIST];
  logic h_rinc [3][HIST];

  int PAR [3] = '{0, 1, 2};
  int LEN [3] = '{40, 44, 44};
  int m_k [3] = '{0, 0, 0};
  bit m_done [3] = '{0, 0, 0};
  bit m_bits [3][12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int count_hist(input int sel, input int i, input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) begin
      if (c >= 0 && c < HIST) begin
        case (sel)
          0:       n += (h_rinc[i][c] === 1'b1) ? 1 : 0;
          default: n += (h_done[i][c] === 1'b1) ? 1 : 0;
        endcase
      end
    end
    return n;
  endfunction

  task automatic refresh();
    rempty[0] = (q0.size() == 0);
    rempty[1] = (q1.size() == 0);
    rempty[2] = (q2.size() == 0);
    rdata[0]  = (q0.size() != 0) ? q0[0] : 8'h00;
    rdata[1]  = (q1.size() != 0) ? q1[0] : 8'h00;
    rdata[2]  = (q2.size() != 0) ? q2[0] : 8'h00;
  endtask

  // The bench plays the FIFO: a pop seen mid-cycle retires the head just after the edge.
  task automatic tick();
    @(posedge rclk);
    #1;
    cyc++;
    if (pop_seen[0] && q0.size() != 0) void'(q0.pop_front());
    if (pop_seen[1] && q1.size() != 0) void'(q1.pop_front());
    if (pop_seen[2] && q2.size() != 0) void'(q2.pop_front());
    refresh();
  endtask

  // Model: each frame is a list of bit levels; m_k is the 1-based cycle within the frame, 0 when idle.
  initial begin
    forever begin
      @(negedge rclk);
      pop_seen = rinc;
      for (int i = 0; i < 3; i++) begin
        bit active, exp_tx, exp_pop;
        active  = (m_k[i] >= 1) && (m_k[i] <= LEN[i]);
        exp_tx  = active ? m_bits[i][(m_k[i] - 1) / CPB] : 1'b1;
        exp_pop = rrst_n && tx_en && !rempty[i] && (m_k[i] == 0 || m_k[i] == LEN[i]);
        if (cyc < HIST) begin
          h_tx[i][cyc]   = tx[i];
          h_busy[i][cyc] = busy[i];
          h_done[i][cyc] = tx_done[i];
          h_rinc[i][cyc] = rinc[i];
        end
        if (cyc >= 1) begin
          check($sformatf("c%0d u%0d rinc", cyc, i), int'(rinc[i]), int'(exp_pop));
          check($sformatf("c%0d u%0d tx", cyc, i), int'(tx[i]), int'(exp_tx));
          check($sformatf("c%0d u%0d busy", cyc, i), int'(busy[i]), int'(active));
          check($sformatf("c%0d u%0d tx_done", cyc, i), int'(tx_done[i]), int'(m_done[i]));
        end
        if (!rrst_n) begin
          m_k[i]    = 0;
          m_done[i] = 1'b0;
        end else begin
          m_done[i] = (m_k[i] == LEN[i]);
          if (exp_pop) begin
            m_k[i] = 1;
            m_bits[i][0] = 1'b0;
            for (int b = 0; b < 8; b++) m_bits[i][1 + b] = rdata[i][b];
            m_bits[i][9]  = (PAR[i] == 0) ? 1'b1 : ((^rdata[i]) ^ (PAR[i] == 2));
            m_bits[i][10] = 1'b1;
            m_bits[i][11] = 1'b1;
          end else if (active && m_k[i] < LEN[i]) begin
            m_k[i]++;
          end else begin
            m_k[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    int t0;
    rrst_n = 1'b0;
    tx_en  = 1'b1;
    q0.push_back(8'hA5);
    q1.push_back(8'h07);
    q2.push_back(8'h07);
    refresh();

    // Reset held for cycles 0..4 with data waiting, released at cycle 5.
    repeat (5) tick();
    rrst_n = 1'b1;
    t0 = cyc;
    repeat (50) tick();
    check("rst_rinc", count_hist(0, 0, 1, t0 - 1), 0);
    check("rst_tx", int'(h_tx[0][t0 - 1]), 1);
    check("a5_pop_t0", int'(h_rinc[0][t0]), 1);
    check("a5_start", int'(h_tx[0][t0 + 1]), 0);
    check("a5_start_end", int'(h_tx[0][t0 + 4]), 0);
    check("a5_bit0", int'(h_tx[0][t0 + 5]), 1);
    check("a5_bit1", int'(h_tx[0][t0 + 9]), 0);
    check("a5_bit7", int'(h_tx[0][t0 + 33]), 1);
    check("a5_stop", int'(h_tx[0][t0 + 37]), 1);
    check("a5_done40", int'(h_done[0][t0 + 40]), 0);
    check("a5_done41", int'(h_done[0][t0 + 41]), 1);
    check("a5_busy41", int'(h_busy[0][t0 + 41]), 0);
    check("a5_one_pop", count_hist(0, 0, t0, t0 + 49), 1);
    check("even_par", int'(h_tx[1][t0 + 37]), 1);
    check("even_stop", int'(h_tx[1][t0 + 41]), 1);
    check("even_done", int'(h_done[1][t0 + 45]), 1);
    check("odd_par", int'(h_tx[2][t0 + 37]), 0);

    // Back-to-back 0x00 then 0xFF.
    tick();
    q0.push_back(8'h00);
    q0.push_back(8'hFF);
    refresh();
    t0 = cyc;
    repeat (90) tick();
    check("b2b_pop1", int'(h_rinc[0][t0]), 1);
    check("b2b_pop2", int'(h_rinc[0][t0 + 40]), 1);
    check("b2b_stop40", int'(h_tx[0][t0 + 40]), 1);
    check("b2b_start41", int'(h_tx[0][t0 + 41]), 0);
    check("b2b_start44", int'(h_tx[0][t0 + 44]), 0);
    check("b2b_bit0", int'(h_tx[0][t0 + 45]), 1);
    check("b2b_busy41", int'(h_busy[0][t0 + 41]), 1);
    check("b2b_pops", count_hist(0, 0, t0, t0 + 89), 2);
    check("b2b_dones", count_hist(1, 0, t0, t0 + 89), 2);

    // tx_en dropped at frame cycle 10 with another byte still queued.
    tick();
    q0.push_back(8'h3C);
    q0.push_back(8'h55);
    refresh();
    t0 = cyc;
    repeat (10) tick();
    tx_en = 1'b0;
    repeat (40) tick();
    check("en_done41", int'(h_done[0][t0 + 41]), 1);
    check("en_no_rinc", count_hist(0, 0, t0 + 1, t0 + 49), 0);
    check("en_tx_idle", int'(h_tx[0][t0 + 49]), 1);
    check("en_q_left", q0.size(), 1);

    // tx_en rising in IDLE with data waiting pops in that same cycle.
    q0.delete();
    q0.push_back(8'h11);
    refresh();
    tick();
    tick();
    tx_en = 1'b1;
    t0 = cyc;
    repeat (50) tick();
    check("en_rise_prev", int'(h_rinc[0][t0 - 1]), 0);
    check("en_rise_pop", int'(h_rinc[0][t0]), 1);

    // Reset at frame cycle 20, held three cycles, then the queued byte is sent.
    tick();
    q0.push_back(8'hA5);
    q0.push_back(8'h5A);
    refresh();
    t0 = cyc;
    repeat (20) tick();
    rrst_n = 1'b0;
    repeat (3) tick();
    rrst_n = 1'b1;
    repeat (50) tick();
    check("rst_mid_tx20", int'(h_tx[0][t0 + 20]), 0);
    check("rst_mid_busy20", int'(h_busy[0][t0 + 20]), 1);
    check("rst_mid_tx21", int'(h_tx[0][t0 + 21]), 1);
    check("rst_mid_busy21", int'(h_busy[0][t0 + 21]), 0);
    check("rst_mid_rinc", count_hist(0, 0, t0 + 20, t0 + 22), 0);
    check("rst_mid_nodone", count_hist(1, 0, t0 + 1, t0 + 22), 0);
    check("rst_mid_repop", int'(h_rinc[0][t0 + 23]), 1);
    check("rst_mid_done", int'(h_done[0][t0 + 64]), 1);
    check("rst_mid_q_empty", q0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
